bsg_cover_mc: RTL and testbench
===============================

// Module: bsg_cover_mc
// PURPOSE
//  Multi-channel coverage collector. Up to num_chan_p coverage sources feed one deduplicating
//  record store; each unique {channel, value} pair is kept once. Store fills or flush_i -> block
//  drains records serially on an out_width_p stream and raises gate_o to stall the sources.
//  Single-clock core-side collector; sits ahead of the AXI coverage drain.
// PARAMETERS
//  num_chan_p   2   number of input channels (>=1); lg_chan_lp = BSG_SAFE_CLOG2(num_chan_p)
//  width_p      16  coverage value width per channel
//  els_p        4   record store depth (>=2)
//  out_width_p  8   drain stream width
//  cnt_width_p  8   hit-counter width (used only with BSG_COVER_MC_HIT_COUNT_EN)
// PORTS
//  clk_i      in   1                     clock
//  reset_i    in   1                     synchronous, active-high reset
//  v_i        in   num_chan_p            per-channel coverage valid
//  data_i     in   num_chan_p*width_p    per-channel value; channel c at [c*width_p+:width_p]
//  ready_o    out  num_chan_p            per-channel accept (one-hot or zero)
//  flush_i    in   1                     request drain of a partially filled store
//  gate_o     out  1                     1 while draining; sources must hold
//  count_o    out  BSG_SAFE_CLOG2(els_p+1) valid records held
//  v_o        out  1                     drain beat valid
//  data_o     out  out_width_p           drain beat
//  last_o     out  1                     final beat of final record
//  ready_i    in   1                     drain consumer ready
// BEHAVIOUR
//  - One clock; reset_i is synchronous and active-high. Reset: state FILL, all records invalid,
//    rr pointer 0; ready_o=0 for that cycle, then gate_o=0, count_o=0, v_o=0, last_o=0, data_o=0.
//  - Record = {chan_id[lg_chan_lp], value[width_p]} (+ hit[cnt_width_p] in MSBs if enabled);
//    beats_lp = CDIV(rec_w, out_width_p); record zero-padded at top.
//  - FILL: round-robin grant among asserted v_i (pointer moves past winner on accept);
//    ready_o[g]=1 only for grant g. Accept = v_i[g]&ready_o[g]. Record compared against all
//    valid records combinationally: match -> dropped; else written at slot count_o,
//    count_o+1 next cycle. Written record visible to compare from next cycle.
//  - FILL->DRAIN when a write makes count_o==els_p, or flush_i=1 with count_o (after this
//    cycle's write) >0. flush_i with empty store: no effect. flush_i same cycle as an accept:
//    accept completes, then DRAIN.
//  - DRAIN: ready_o=0, gate_o=1, flush_i ignored. Records 0..count_o-1 emitted in slot order,
//    beats MSB-first; v_o=1 every DRAIN cycle; beat advances on v_o&ready_i; data_o held
//    while ready_i=0. last_o=1 only with final beat of record count_o-1. That handshake clears
//    all records, count_o=0, -> FILL next cycle (ready_o may assert that cycle).
//  - Reset mid-DRAIN discards partial output; no last_o issued.
//  - Latency: accept at t -> count_o updated t+1; DRAIN entry -> first beat t+1.
// CONFIGURATION
//  BSG_COVER_MC_HIT_COUNT_EN defined: per-record saturating hit counter, 1 on insert, +1 on each
//  matching accept, saturates at 2^cnt_width_p-1; emitted in record MSBs.
//  Undefined: no counters; rec_w = lg_chan_lp+width_p; duplicates silently dropped.
// STRUCTURE
//  bsg_cover_mc_pkg: state enum {FILL, DRAIN}; record width/beat-count functions.
//  Sub-module bsg_cover_mc_serializer: record -> beats_lp MSB-first beats, valid/ready,
//  beat counter, last-beat flag. Arbitration uses existing bsg_arb_round_robin.
// TESTING
//  (defaults, counter off: rec_w=17, beats_lp=3)
//  1 ch0 sends 0x1234 x3 -> count_o=1, one write; ch0 0x1234 then ch1 0x1234 -> count_o=2.
//  2 v_i=2'b11 held 4 cycles, distinct values -> grants alternate 0,1,0,1; store full ->
//    gate_o=1, drains 12 beats, last_o on 12th; record 0 of ch0 0x00AA = beats 0x00,0x00,0xAA.
//  3 2 records, flush_i=1 -> DRAIN, 6 beats, last_o on 6th, count_o=0, back to FILL.
//  4 ready_i toggling 1-0 in DRAIN -> data_o stable while 0, no beat lost or duplicated.
//  5 reset_i asserted at beat 5 of drain -> next cycle v_o=0, count_o=0, gate_o=0.
//  6 HIT_COUNT_EN, cnt_width_p=2: value sent 5x, flush -> hit field 3 (saturated), beats_lp=3.

Source files
------------

// File: rtl/bsg_cover_mc_pkg.sv
// rtl/bsg_cover_mc_pkg.sv - shared types and sizing helpers for the coverage collector
//
// Purpose: FSM state enum plus constant functions that size the record
//          and the drain beat count.
// Ports:   none (package).
package bsg_cover_mc_pkg;

   typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_e;

   // Bit width needed to index n items; never returns 0 so a single item
   // still gets a 1-bit field.
   function automatic int safe_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r == 0) ? 1 : r;
   endfunction

   function automatic int cdiv(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Record = {hit (optional), chan_id, value}
   function automatic int rec_width(input int lg_chan, input int width,
                                    input int cnt_width, input bit hit_en);
      return lg_chan + width + (hit_en ? cnt_width : 0);
   endfunction

endpackage

// File: rtl/bsg_cover_mc_serializer.sv
// rtl/bsg_cover_mc_serializer.sv - splits one record into MSB-first drain beats
//
// Purpose: presents the record selected by the top as beats_p beats of
//          out_width_p bits, most significant beat first, with a
//          valid/ready handshake. The record is zero-padded at the top.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   en_i             1 while the collector is draining (drives v_o)
//   rec_i            current record
//   last_rec_i       rec_i is the final record of this drain
//   v_o, data_o      beat valid / beat data (data_o is 0 when not enabled)
//   last_o           final beat of the final record
//   ready_i          consumer ready
//   rec_done_o       handshake on the final beat of the current record
module bsg_cover_mc_serializer
   import bsg_cover_mc_pkg::*;
#(
   parameter int rec_w_p     = 17,
   parameter int out_width_p = 8,
   parameter int beats_p     = 3
)(
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   en_i,
   input  logic [rec_w_p-1:0]     rec_i,
   input  logic                   last_rec_i,
   output logic                   v_o,
   output logic [out_width_p-1:0] data_o,
   output logic                   last_o,
   input  logic                   ready_i,
   output logic                   rec_done_o
);

   localparam int bw_lp  = safe_clog2(beats_p);
   localparam int pad_lp = beats_p * out_width_p;

   logic [bw_lp-1:0]  beat_r;
   logic [pad_lp-1:0] padded;
   logic [pad_lp-1:0] shifted;
   logic              last_beat;

   assign padded    = pad_lp'(rec_i);
   assign shifted   = padded >> ((beats_p - 1 - int'(beat_r)) * out_width_p);
   assign last_beat = (beat_r == bw_lp'(beats_p - 1));

   assign v_o        = en_i;
   assign data_o     = en_i ? shifted[out_width_p-1:0] : '0;
   assign last_o     = en_i & last_beat & last_rec_i;
   assign rec_done_o = en_i & ready_i & last_beat;

   always_ff @(posedge clk_i) begin
      if (reset_i || !en_i) begin
         beat_r <= '0;
      end else if (ready_i) begin
         beat_r <= last_beat ? '0 : beat_r + 1'b1;
      end
   end

endmodule

// File: rtl/bsg_cover_mc.sv
// rtl/bsg_cover_mc.sv - multi-channel deduplicating coverage collector
//
// Purpose: round-robin accepts coverage values from num_chan_p channels,
//          keeps each unique {channel, value} once, and drains the store
//          serially when it fills or on flush_i. gate_o stalls sources
//          while draining.
//          Optional build macro BSG_COVER_MC_HIT_COUNT_EN adds a per-record
//          saturating hit counter carried in the record MSBs.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   v_i, data_i      per-channel valid / value (channel c at [c*width_p+:width_p])
//   ready_o          per-channel accept, one-hot or zero
//   flush_i          drain a partially filled store
//   gate_o           1 while draining
//   count_o          number of valid records
//   v_o, data_o      drain beat valid / data
//   last_o           final beat of final record
//   ready_i          drain consumer ready
module bsg_cover_mc
   import bsg_cover_mc_pkg::*;
#(
   parameter int num_chan_p  = 2,
   parameter int width_p     = 16,
   parameter int els_p       = 4,
   parameter int out_width_p = 8,
   parameter int cnt_width_p = 8
)(
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic [num_chan_p-1:0]             v_i,
   input  logic [num_chan_p*width_p-1:0]     data_i,
   output logic [num_chan_p-1:0]             ready_o,
   input  logic                              flush_i,
   output logic                              gate_o,
   output logic [safe_clog2(els_p+1)-1:0]    count_o,
   output logic                              v_o,
   output logic [out_width_p-1:0]            data_o,
   output logic                              last_o,
   input  logic                              ready_i
);

`ifdef BSG_COVER_MC_HIT_COUNT_EN
   localparam bit hit_en_lp = 1'b1;
`else
   localparam bit hit_en_lp = 1'b0;
`endif
   localparam int lg_chan_lp = safe_clog2(num_chan_p);
   localparam int cw_lp      = safe_clog2(els_p + 1);
   localparam int iw_lp      = safe_clog2(els_p);
   localparam int rec_w_lp   = rec_width(lg_chan_lp, width_p, cnt_width_p, hit_en_lp);
   localparam int beats_lp   = cdiv(rec_w_lp, out_width_p);

   state_e                state_r, state_n;
   logic [cw_lp-1:0]      count_r, count_n;
   logic [iw_lp-1:0]      rd_idx_r, rd_idx_n;
   logic [lg_chan_lp-1:0] rr_ptr_r, rr_ptr_n;

   logic [lg_chan_lp-1:0] chan_r [els_p];
   logic [width_p-1:0]    val_r  [els_p];
`ifdef BSG_COVER_MC_HIT_COUNT_EN
   logic [cnt_width_p-1:0] hit_r [els_p];
`endif

   logic                  gnt_v;
   logic [lg_chan_lp-1:0] gnt_idx;
   logic [width_p-1:0]    in_val;
   logic                  accept;
   logic                  wr;
   logic [els_p-1:0]      match_vec;
   logic [rec_w_lp-1:0]   cur_rec;
   logic                  last_rec;
   logic                  rec_done;

   // Round-robin: scan from rr_ptr_r upward with wrap; descending loop so
   // the lowest offset from the pointer is the last (winning) assignment.
   always_comb begin
      int j;
      gnt_v   = 1'b0;
      gnt_idx = '0;
      j       = 0;
      for (int i = num_chan_p - 1; i >= 0; i--) begin
         j = int'(rr_ptr_r) + i;
         if (j >= num_chan_p) j = j - num_chan_p;
         if (v_i[j]) begin
            gnt_v   = 1'b1;
            gnt_idx = lg_chan_lp'(j);
         end
      end
   end

   assign accept = (state_r == FILL) && !reset_i && gnt_v;

   always_comb begin
      ready_o = '0;
      in_val  = '0;
      for (int c = 0; c < num_chan_p; c++) begin
         if (gnt_idx == lg_chan_lp'(c)) begin
            ready_o[c] = accept;
            in_val     = data_i[c*width_p +: width_p];
         end
      end
   end

   // Only slots below count_r hold valid records.
   always_comb begin
      match_vec = '0;
      for (int i = 0; i < els_p; i++) begin
         match_vec[i] = (i < int'(count_r)) && (chan_r[i] == gnt_idx) && (val_r[i] == in_val);
      end
   end

   assign wr = accept && !(|match_vec);

   always_comb begin
      cur_rec = '0;
      for (int i = 0; i < els_p; i++) begin
         if (rd_idx_r == iw_lp'(i)) begin
`ifdef BSG_COVER_MC_HIT_COUNT_EN
            cur_rec = {hit_r[i], chan_r[i], val_r[i]};
`else
            cur_rec = {chan_r[i], val_r[i]};
`endif
         end
      end
   end

   assign last_rec = (int'(rd_idx_r) == int'(count_r) - 1);

   always_comb begin
      state_n  = state_r;
      count_n  = count_r;
      rd_idx_n = rd_idx_r;
      rr_ptr_n = rr_ptr_r;
      case (state_r)
         FILL: begin
            if (accept) begin
               rr_ptr_n = (gnt_idx == lg_chan_lp'(num_chan_p - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (wr) count_n = count_r + 1'b1;
            // Flush looks at the count including this cycle's write.
            if ((count_n == cw_lp'(els_p)) || (flush_i && (count_n != '0))) begin
               state_n  = DRAIN;
               rd_idx_n = '0;
            end
         end
         DRAIN: begin
            if (rec_done) begin
               if (last_rec) begin
                  state_n  = FILL;
                  count_n  = '0;
                  rd_idx_n = '0;
               end else begin
                  rd_idx_n = rd_idx_r + 1'b1;
               end
            end
         end
         default: state_n = FILL;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r  <= FILL;
         count_r  <= '0;
         rd_idx_r <= '0;
         rr_ptr_r <= '0;
      end else begin
         state_r  <= state_n;
         count_r  <= count_n;
         rd_idx_r <= rd_idx_n;
         rr_ptr_r <= rr_ptr_n;
      end
   end

   // Record payload needs no reset: validity is defined by count_r.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < els_p; i++) begin
         if (wr && (i == int'(count_r))) begin
            chan_r[i] <= gnt_idx;
            val_r[i]  <= in_val;
`ifdef BSG_COVER_MC_HIT_COUNT_EN
            hit_r[i]  <= cnt_width_p'(1);
`endif
         end
`ifdef BSG_COVER_MC_HIT_COUNT_EN
         if (accept && match_vec[i] && (hit_r[i] != '1)) begin
            hit_r[i] <= hit_r[i] + 1'b1;
         end
`endif
      end
   end

   assign gate_o  = (state_r == DRAIN);
   assign count_o = count_r;

   bsg_cover_mc_serializer #(
      .rec_w_p     (rec_w_lp),
      .out_width_p (out_width_p),
      .beats_p     (beats_lp)
   ) ser (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .en_i       (state_r == DRAIN),
      .rec_i      (cur_rec),
      .last_rec_i (last_rec),
      .v_o        (v_o),
      .data_o     (data_o),
      .last_o     (last_o),
      .ready_i    (ready_i),
      .rec_done_o (rec_done)
   );

endmodule

// File: tb/tb_bsg_cover_mc.sv
// tb/tb_bsg_cover_mc.sv - scoreboard bench for bsg_cover_mc
module tb_bsg_cover_mc;

   logic        clk = 1'b0;
   logic        reset_i;
   logic [1:0]  v_i;
   logic [31:0] data_i;
   logic [1:0]  ready_o;
   logic        flush_i;
   logic        gate_o;
   logic [2:0]  count_o;
   logic        v_o;
   logic [7:0]  data_o;
   logic        last_o;
   logic        ready_i;

   int vec;
   int errs;
   int beats_seen;
   logic [8:0] exp_q [$];

   always #5 clk = ~clk;

   bsg_cover_mc #(
      .num_chan_p  (2),
      .width_p     (16),
      .els_p       (4),
      .out_width_p (8),
      .cnt_width_p (2)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .v_i     (v_i),
      .data_i  (data_i),
      .ready_o (ready_o),
      .flush_i (flush_i),
      .gate_o  (gate_o),
      .count_o (count_o),
      .v_o     (v_o),
      .data_o  (data_o),
      .last_o  (last_o),
      .ready_i (ready_i)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected beats of one 24-bit padded record {hit, chan, value}.
   task automatic push_rec(input logic [1:0] hit, input logic chan,
                           input logic [15:0] val, input bit last_rec);
      logic [23:0] r;
      r = {5'b0, hit, chan, val};
      for (int b = 0; b < 3; b++) begin
         exp_q.push_back({(last_rec && b == 2), r[(2-b)*8 +: 8]});
      end
   endtask

   task automatic drain_wait(input string name, input bit toggle);
      int n;
      n = 0;
      while (n < 300) begin
         @(negedge clk);
         if (!gate_o && exp_q.size() == 0) break;
         @(posedge clk);
         #1;
         if (toggle) ready_i = ~ready_i;
         n++;
      end
      ready_i = 1'b1;
      chk({name, "_timeout"}, 32'(n < 300), 32'd1);
   endtask

   logic [15:0] ch0_vals [4];
   logic [15:0] ch1_vals [4];

   initial begin
      int n;
      int base;
      logic       held_v;
      logic [7:0] held_d;
      logic [8:0] e;

      vec = 0; errs = 0; beats_seen = 0;
      reset_i = 1'b1; v_i = 2'b01; data_i = '0; flush_i = 1'b0; ready_i = 1'b1;

      fork
         begin
            #200000;
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1);
         end
      join_none

      // Output monitor / scoreboard checker
      fork
         begin
            held_v = 1'b0;
            held_d = '0;
            forever begin
               @(negedge clk);
               if (v_o) begin
                  if (held_v) chk("hold_data", 32'(data_o), 32'(held_d));
                  if (ready_i) begin
                     held_v = 1'b0;
                     beats_seen++;
                     if (exp_q.size() == 0) begin
                        vec++;
                        errs++;
                        $display("FAIL beat_unexpected: got 0x%0h expected none", {last_o, data_o});
                     end else begin
                        e = exp_q.pop_front();
                        chk("beat", 32'({last_o, data_o}), 32'(e));
                     end
                  end else begin
                     held_v = 1'b1;
                     held_d = data_o;
                  end
               end else begin
                  held_v = 1'b0;
               end
            end
         end
      join_none

      // Reset
      tick; tick;
      @(negedge clk);
      chk("reset_ready_o", 32'(ready_o), 32'd0);
      tick;
      reset_i = 1'b0; v_i = 2'b00;
      @(negedge clk);
      chk("reset_gate_o", 32'(gate_o), 32'd0);
      chk("reset_count_o", 32'(count_o), 32'd0);
      chk("reset_v_o", 32'(v_o), 32'd0);
      chk("reset_last_o", 32'(last_o), 32'd0);
      chk("reset_data_o", 32'(data_o), 32'd0);
      tick;

      // Duplicate suppression
      v_i = 2'b01; data_i = {16'h0000, 16'h1234};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("dup_ready_o", 32'(ready_o), 32'd1);
         tick;
      end
      v_i = 2'b00;
      @(negedge clk);
      chk("dup_count_1", 32'(count_o), 32'd1);
      tick;
      v_i = 2'b01; tick;
      v_i = 2'b10; data_i = {16'h1234, 16'h1234}; tick;
      v_i = 2'b00;
      @(negedge clk);
      chk("dup_count_2", 32'(count_o), 32'd2);
      tick;

      // Flush of a partial store
      push_rec(2'd0, 1'b0, 16'h1234, 1'b0);
      push_rec(2'd0, 1'b1, 16'h1234, 1'b1);
      flush_i = 1'b1; tick; flush_i = 1'b0;
      @(negedge clk);
      chk("flush_gate_o", 32'(gate_o), 32'd1);
      chk("flush_ready_o", 32'(ready_o), 32'd0);
      drain_wait("flush_drain", 1'b0);
      chk("flush_count_after", 32'(count_o), 32'd0);
      chk("flush_gate_after", 32'(gate_o), 32'd0);
      tick;

      // Flush with empty store does nothing
      flush_i = 1'b1; tick; flush_i = 1'b0;
      @(negedge clk);
      chk("empty_flush_gate", 32'(gate_o), 32'd0);
      tick;

      // Round-robin fill to full, drain with ready_i toggling
      ch0_vals = '{16'h00AA, 16'h1111, 16'h00BB, 16'h2222};
      ch1_vals = '{16'h3333, 16'h0CC1, 16'h4444, 16'h0DD1};
      push_rec(2'd0, 1'b0, 16'h00AA, 1'b0);
      push_rec(2'd0, 1'b1, 16'h0CC1, 1'b0);
      push_rec(2'd0, 1'b0, 16'h00BB, 1'b0);
      push_rec(2'd0, 1'b1, 16'h0DD1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         v_i = 2'b11; data_i = {ch1_vals[k], ch0_vals[k]};
         @(negedge clk);
         chk("rr_grant", 32'(ready_o), (k % 2 == 0) ? 32'd1 : 32'd2);
         tick;
      end
      v_i = 2'b00;
      @(negedge clk);
      chk("full_gate_o", 32'(gate_o), 32'd1);
      chk("full_count_o", 32'(count_o), 32'd4);
      tick;
      drain_wait("full_drain", 1'b1);
      chk("full_count_after", 32'(count_o), 32'd0);
      tick;

      // Reset in the middle of a drain
      for (int k = 0; k < 4; k++) begin
         v_i = 2'b01; data_i = {16'h0000, 16'(k + 1)};
         tick;
      end
      v_i = 2'b00;
      exp_q.push_back({1'b0, 8'h00});
      exp_q.push_back({1'b0, 8'h00});
      exp_q.push_back({1'b0, 8'h01});
      exp_q.push_back({1'b0, 8'h00});
      exp_q.push_back({1'b0, 8'h00});
      base = beats_seen;
      n = 0;
      while (beats_seen < base + 4 && n < 100) begin
         tick;
         n++;
      end
      chk("mid_reset_wait_timeout", 32'(n < 100), 32'd1);
      reset_i = 1'b1; v_i = 2'b11;
      @(negedge clk);
      chk("mid_reset_ready_o", 32'(ready_o), 32'd0);
      tick;
      reset_i = 1'b0; v_i = 2'b00;
      @(negedge clk);
      chk("mid_reset_v_o", 32'(v_o), 32'd0);
      chk("mid_reset_count_o", 32'(count_o), 32'd0);
      chk("mid_reset_gate_o", 32'(gate_o), 32'd0);
      chk("mid_reset_last_o", 32'(last_o), 32'd0);
      tick;
      @(negedge clk);
      chk("mid_reset_leftover", 32'(exp_q.size()), 32'd0);
      tick;

`ifdef BSG_COVER_MC_HIT_COUNT_EN
      // Saturating hit counter (2 bits)
      v_i = 2'b10; data_i = {16'h5678, 16'h0000};
      repeat (5) tick;
      v_i = 2'b00;
      @(negedge clk);
      chk("hit_count_o", 32'(count_o), 32'd1);
      tick;
      push_rec(2'd3, 1'b1, 16'h5678, 1'b1);
      flush_i = 1'b1; tick; flush_i = 1'b0;
      drain_wait("hit_drain", 1'b0);
      tick;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
